bcd_time_counter: RTL



---
 rtl/clock_pkg.sv | 21 ++
 rtl/bcd_digit_counter.sv | 30 +++
 rtl/bcd_time_counter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared constants and types for the BCD timekeeping block.
package clock_pkg;

    // One BCD digit, always held in the range 0..9.
    typedef logic [3:0] bcd_t;

    localparam int SEC_MSB_MAX = 5;
    localparam int LSB_MAX     = 9;
    localparam int HR24_MAX    = 23;
    localparam int HR12_MAX    = 12;

    // Display refresh handshake. STROBE_PEND is a strobe cycle during which a
    // further change was already recorded, so a new refresh must follow it.
    typedef enum logic [1:0] {
        RF_IDLE        = 2'd0,
        RF_PENDING     = 2'd1,
        RF_STROBE      = 2'd2,
        RF_STROBE_PEND = 2'd3
    } refresh_state_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit that counts 0..MAX. The carry is combinational so that
// a chain of digits advances together on the same clock edge.
module bcd_digit_counter
    import clock_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [3:0] o_value,
    output logic       o_carry
);

    bcd_t r_value;

    assign o_value = r_value;
    assign o_carry = i_inc & ~i_clr & (r_value == 4'(MAX));

    // Digit register: clear has priority over increment, wrap MAX -> 0.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_value <= 4'd0;
        end else if (i_inc) begin
            r_value <= (r_value == 4'(MAX)) ? 4'd0 : r_value + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss timekeeper with button setting, 12/24 h modes and a
// refresh strobe handshake towards the serial display output stage.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int TWELVE_HOUR = 0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_sec_stb,
    input  logic       i_set_mode,
    input  logic       i_set_min_stb,
    input  logic       i_set_hr_stb,
    input  logic       i_out_busy,
    output logic [3:0] o_hours_msb,
    output logic [3:0] o_hours_lsb,
    output logic [3:0] o_minutes_msb,
    output logic [3:0] o_minutes_lsb,
    output logic [3:0] o_seconds_msb,
    output logic [3:0] o_seconds_lsb,
    output logic       o_colon,
    output logic       o_pm,
    output logic       o_refresh_stb
);

    // Hours value (0..23) to two BCD digits.
    function automatic logic [7:0] hr_to_bcd(input logic [4:0] b);
        logic [3:0] tens;
        if (b >= 5'd20) begin
            tens = 4'd2;
        end else if (b >= 5'd10) begin
            tens = 4'd1;
        end else begin
            tens = 4'd0;
        end
        return {tens, 4'(b - 5'(tens) * 5'd10)};
    endfunction

    logic           w_run;
    logic           w_set;
    logic [3:0]     w_sec_lsb;
    logic [3:0]     w_sec_msb;
    logic [3:0]     w_min_lsb;
    logic [3:0]     w_min_msb;
    logic           w_sec_lsb_carry;
    logic           w_sec_msb_carry;
    logic           w_min_lsb_carry;
    logic           w_min_msb_carry;
    logic           w_hr_inc;
    logic           w_change;
    logic [4:0]     w_hr_bin;
    logic [4:0]     w_hr_bin_next;
    logic           w_pm_next;
    logic [7:0]     w_hr_bcd_next;
    bcd_t           r_hr_msb;
    bcd_t           r_hr_lsb;
    logic           r_pm;
    refresh_state_t r_state;
    refresh_state_t w_state_next;

    assign w_run = i_en & ~i_set_mode;
    assign w_set = i_en &  i_set_mode;

    // Seconds are cleared every enabled set-mode cycle, which both forces
    // them to 00 on entry and keeps them there.
    bcd_digit_counter #(.MAX(LSB_MAX)) u_sec_lsb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_run & i_sec_stb),
        .i_clr   (w_set),
        .o_value (w_sec_lsb),
        .o_carry (w_sec_lsb_carry)
    );

    bcd_digit_counter #(.MAX(SEC_MSB_MAX)) u_sec_msb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_sec_lsb_carry),
        .i_clr   (w_set),
        .o_value (w_sec_msb),
        .o_carry (w_sec_msb_carry)
    );

    bcd_digit_counter #(.MAX(LSB_MAX)) u_min_lsb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   ((w_run & w_sec_msb_carry) | (w_set & i_set_min_stb)),
        .i_clr   (1'b0),
        .o_value (w_min_lsb),
        .o_carry (w_min_lsb_carry)
    );

    bcd_digit_counter #(.MAX(SEC_MSB_MAX)) u_min_msb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_min_lsb_carry),
        .i_clr   (1'b0),
        .o_value (w_min_msb),
        .o_carry (w_min_msb_carry)
    );

    // Minute wrap only carries into hours while running; in set mode the
    // hour button is the sole source of hour increments.
    assign w_hr_inc = (w_run & w_min_msb_carry) | (w_set & i_set_hr_stb);

    // Every increment moves a digit, and the set-mode clear moves one only
    // when the seconds are not already 00.
    assign w_change = (w_run & i_sec_stb)
                    | (w_set & (i_set_min_stb | i_set_hr_stb))
                    | (w_set & ((w_sec_msb != 4'd0) | (w_sec_lsb != 4'd0)));

    // Next hour value and PM flag for either 12 h or 24 h counting.
    always_comb begin
        w_hr_bin      = 5'(r_hr_msb) * 5'd10 + 5'(r_hr_lsb);
        w_hr_bin_next = w_hr_bin + 5'd1;
        w_pm_next     = r_pm;
        if (TWELVE_HOUR != 0) begin
            if (w_hr_bin == 5'(HR12_MAX)) begin
                w_hr_bin_next = 5'd1;
            end
            if (w_hr_bin == 5'(HR12_MAX - 1)) begin
                w_pm_next = ~r_pm;
            end
        end else if (w_hr_bin == 5'(HR24_MAX)) begin
            w_hr_bin_next = 5'd0;
        end
        w_hr_bcd_next = hr_to_bcd(w_hr_bin_next);
    end

    // Hours and PM registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hr_msb <= (TWELVE_HOUR != 0) ? 4'd1 : 4'd0;
            r_hr_lsb <= (TWELVE_HOUR != 0) ? 4'd2 : 4'd0;
            r_pm     <= 1'b0;
        end else if (w_hr_inc) begin
            r_hr_msb <= w_hr_bcd_next[7:4];
            r_hr_lsb <= w_hr_bcd_next[3:0];
            r_pm     <= w_pm_next;
        end
    end

    // Refresh state register; reset leaves a refresh pending so the display
    // is initialised once reset is released.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RF_PENDING;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Refresh next state: strobe when pending and the output stage is idle,
    // never twice in a row, and fold changes seen meanwhile into one pending.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RF_IDLE: begin
                if (w_change) begin
                    w_state_next = RF_PENDING;
                end
            end
            RF_PENDING: begin
                if (!i_out_busy) begin
                    w_state_next = w_change ? RF_STROBE_PEND : RF_STROBE;
                end
            end
            RF_STROBE: begin
                w_state_next = w_change ? RF_PENDING : RF_IDLE;
            end
            RF_STROBE_PEND: begin
                w_state_next = RF_PENDING;
            end
            default: begin
                w_state_next = RF_PENDING;
            end
        endcase
    end

    assign o_refresh_stb = (r_state == RF_STROBE) | (r_state == RF_STROBE_PEND);

    assign o_hours_msb   = r_hr_msb;
    assign o_hours_lsb   = r_hr_lsb;
    assign o_minutes_msb = w_min_msb;
    assign o_minutes_lsb = w_min_lsb;
    assign o_seconds_msb = w_sec_msb;
    assign o_seconds_lsb = w_sec_lsb;
    assign o_pm          = r_pm;
    assign o_colon       = i_set_mode | ~w_sec_lsb[0];

endmodule
